// File: rtl/change_dispenser.sv
// Change dispenser: queues change requests from the vending FSM and drives the coin
// hopper with timed eject pulses, greedy Rs 10 coins first, then a final Rs 5 if needed.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend,
    input  logic [2:0] change,
    input  logic       hopper_ready,
    output logic       eject_10,
    output logic       eject_5,
    output logic       done,
    output logic       busy,
    output logic       overflow,
    output logic       bad_code
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE    = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic          vend_q;
    logic          capture;
    logic          code_bad;
    logic          push_req;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [2:0]    rem_q;
    logic          coin10_q;
    logic [CW-1:0] cnt_q;

    // A request is the first cycle of a vend high level, not the level itself.
    assign capture   = vend && !vend_q;
    assign code_bad  = (change >= 3'd6);
    assign push_req  = capture && (change != 3'd0) && !code_bad;
    assign fifo_full = (count_q == FULL_COUNT);
    assign do_push   = push_req && !fifo_full;
    assign do_pop    = (state_q == IDLE) && (count_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            vend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vend_q <= vend;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + OCC_ONE;
                2'b01:   count_q <= count_q - OCC_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; the occupancy count alone
    // decides which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= change;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (count_q != '0) state_d = LOAD;
            LOAD:     state_d = WAIT_RDY;
            WAIT_RDY: if (hopper_ready) state_d = PULSE;
            PULSE:    if (cnt_q == CNT_ONE) state_d = GAP;
            GAP: begin
                if (cnt_q == CNT_ONE) state_d = (rem_q != 3'd0) ? WAIT_RDY : DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // rem counts outstanding change in Rs 5 units; coin10 picks the next coin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= 3'd0;
            coin10_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE:     if (do_pop) rem_q <= mem[rd_ptr_q];
                LOAD:     coin10_q <= (rem_q >= 3'd2);
                WAIT_RDY: if (hopper_ready) cnt_q <= PULSE_LOAD;
                PULSE: begin
                    if (cnt_q == CNT_ONE) begin
                        rem_q <= rem_q - (coin10_q ? 3'd2 : 3'd1);
                        cnt_q <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_ONE) coin10_q <= (rem_q >= 3'd2);
                    else                  cnt_q    <= cnt_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            eject_10 <= 1'b0;
            eject_5  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            eject_10 <= (state_d == PULSE) && coin10_q;
            eject_5  <= (state_d == PULSE) && !coin10_q;
            done     <= (state_d == DONE);
            busy     <= (state_d != IDLE) || (count_q != '0);
            overflow <= overflow || (push_req && fifo_full);
            bad_code <= bad_code || (capture && code_bad);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed timing checks derived from the
// coin schedule plus randomized requests scored against a transaction-level model.
module tb_change_dispenser;

    localparam int P   = 4;
    localparam int G   = 2;
    localparam int D   = 4;
    localparam int PER = P + G + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend = 1'b0;
    logic [2:0] change = 3'd0;
    logic       hopper_ready = 1'b0;
    logic       eject_10, eject_5, done, busy, overflow, bad_code;

    int n_vec = 0;
    int n_err = 0;

    int obs_coins[$];
    int obs_done = 0;
    int run = 0;
    int cur_coin = 0;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .vend(vend), .change(change), .hopper_ready(hopper_ready),
        .eject_10(eject_10), .eject_5(eject_5), .done(done), .busy(busy),
        .overflow(overflow), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: records every completed eject pulse as a coin value.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            run = 0;
        end else begin
            if (eject_10 === 1'b1 && eject_5 === 1'b1)
                check("both_ejects", 32'd1, 32'd0);
            if (eject_10 === 1'b1 || eject_5 === 1'b1) begin
                if (run == 0) cur_coin = (eject_10 === 1'b1) ? 10 : 5;
                run++;
            end else if (run != 0) begin
                obs_coins.push_back(cur_coin);
                check("pulse_width", run, P);
                run = 0;
            end
            if (done === 1'b1) obs_done++;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic rtick;
        hopper_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
    endtask

    function automatic void decompose(input int code, inout int q[$]);
        int r = code;
        while (r > 0) begin
            if (r >= 2) begin q.push_back(10); r -= 2; end
            else        begin q.push_back(5);  r -= 1; end
        end
    endfunction

    task automatic wait_idle(input string tag, input int bound, input bit rnd);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            if (rnd) rtick; else tick;
            n++;
        end
        check({tag, "_idle"}, busy, 32'd0);
    endtask

    task automatic compare_coins(input string tag, input int exp_q[$], input int exp_done);
        check({tag, "_coin_count"}, obs_coins.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_coins.size(); i++)
            check($sformatf("%s_coin%0d", tag, i), obs_coins[i], exp_q[i]);
        check({tag, "_done_count"}, obs_done, exp_done);
    endtask

    // One request with hopper_ready held high; every cycle is compared to the schedule.
    task automatic run_request(input int code);
        int coins[$];
        int n, done_k;
        logic e10, e5;
        decompose(code, coins);
        n = coins.size();
        done_k = 3 + n * (P + G) + (n - 1);
        hopper_ready = 1'b1;
        vend = 1'b1;
        change = 3'(code);
        tick;
        for (int k = 0; k <= done_k + 2; k++) begin
            e10 = 1'b0;
            e5  = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (k >= 3 + i * PER && k < 3 + i * PER + P) begin
                    e10 = (coins[i] == 10);
                    e5  = (coins[i] == 5);
                end
            end
            check($sformatf("code%0d_k%0d", code, k), {eject_10, eject_5, done, busy},
                  {e10, e5, (k == done_k), (k >= 1 && k <= done_k)});
            if (k == 0) vend = 1'b0;
            tick;
        end
    endtask

    initial begin
        int exp_q[$];
        int model_q[$];
        int accepted[$];
        bit in_service;
        bit exp_ovf, exp_bad;
        int exp_done;
        int codes[6] = '{1, 2, 3, 4, 5, 1};
        int rises;
        logic prev;

        // Reset values
        tick;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("reset_idle", {eject_10, eject_5, done, busy, overflow, bad_code}, 6'd0);
            tick;
        end

        // Full schedule per code, starting with the Rs 25 case
        run_request(5);
        for (int c = 1; c <= 4; c++) run_request(c);

        // Held vend gives a single request
        obs_coins.delete();
        obs_done = 0;
        vend = 1'b1;
        change = 3'd2;
        repeat (5) tick;
        vend = 1'b0;
        tick;
        wait_idle("level", 100, 1'b0);
        exp_q = '{10};
        compare_coins("level", exp_q, 1);

        // Code 0 does nothing
        vend = 1'b1;
        change = 3'd0;
        tick;
        vend = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("code0", {eject_10, eject_5, busy}, 3'd0);
            tick;
        end

        // Code 6 is rejected and flagged at the capture edge
        check("bad_before", bad_code, 32'd0);
        vend = 1'b1;
        change = 3'd6;
        tick;
        vend = 1'b0;
        check("bad_set", bad_code, 32'd1);
        repeat (10) tick;
        check("code6_busy", busy, 32'd0);
        compare_coins("code6", exp_q, 1);

        // Handshake stall, then ready dropped mid-pulse
        obs_coins.delete();
        obs_done = 0;
        hopper_ready = 1'b0;
        vend = 1'b1;
        change = 3'd1;
        tick;
        vend = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("stall_k%0d", k), {eject_10, eject_5, busy}, {2'b00, (k >= 1)});
            tick;
        end
        hopper_ready = 1'b1;
        tick;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("stall_pulse%0d", j), {eject_10, eject_5}, {1'b0, (j < P)});
            if (j == 0) hopper_ready = 1'b0;
            tick;
        end
        wait_idle("stall", 50, 1'b0);
        exp_q = '{5};
        compare_coins("stall", exp_q, 1);

        // Queue full: first request in service (stalled), then FIFO fills and one drops
        obs_coins.delete();
        obs_done = 0;
        hopper_ready = 1'b0;
        in_service = 1'b0;
        exp_ovf = 1'b0;
        model_q.delete();
        accepted.delete();
        foreach (codes[i]) begin
            if (!in_service) begin
                in_service = 1'b1;
                accepted.push_back(codes[i]);
            end else if (model_q.size() < D) begin
                model_q.push_back(codes[i]);
                accepted.push_back(codes[i]);
            end else begin
                exp_ovf = 1'b1;
            end
            vend = 1'b1;
            change = 3'(codes[i]);
            tick;
            vend = 1'b0;
            check($sformatf("ovf_req%0d", i), overflow, {31'd0, exp_ovf});
            tick;
        end
        hopper_ready = 1'b1;
        wait_idle("ovf", 400, 1'b0);
        exp_q.delete();
        foreach (accepted[i]) decompose(accepted[i], exp_q);
        compare_coins("ovf", exp_q, accepted.size());

        // Reset during the second coin of code 4
        hopper_ready = 1'b1;
        vend = 1'b1;
        change = 3'd4;
        tick;
        vend = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < 40 && rises < 2; k++) begin
            if (eject_10 === 1'b1 && prev === 1'b0) rises++;
            prev = eject_10;
            if (rises < 2) tick;
        end
        check("rst_second_coin", rises, 32'd2);
        rst = 1'b1;
        tick;
        check("rst_mid", {eject_10, eject_5, done, busy}, 4'd0);
        rst = 1'b0;
        check("rst_sticky", {overflow, bad_code}, 2'd0);
        for (int k = 0; k < 30; k++) begin
            check("rst_after", {eject_10, eject_5, done, busy}, 4'd0);
            tick;
        end

        // Randomized requests against the greedy decomposition model
        obs_coins.delete();
        obs_done = 0;
        exp_q.delete();
        exp_done = 0;
        exp_bad = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int code = $urandom_range(0, 7);
            int len = $urandom_range(1, 3);
            if (code >= 1 && code <= 5) begin
                decompose(code, exp_q);
                exp_done++;
            end else if (code >= 6) begin
                exp_bad = 1'b1;
            end
            vend = 1'b1;
            change = 3'(code);
            rtick;
            change = 3'($urandom_range(0, 7));
            repeat (len - 1) rtick;
            vend = 1'b0;
            rtick;
            rtick;
            wait_idle($sformatf("rand%0d", it), 400, 1'b1);
        end
        compare_coins("rand", exp_q, exp_done);
        check("rand_bad", bad_code, {31'd0, exp_bad});
        check("rand_ovf", overflow, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
